// File: rtl/sc_pkg.sv
// sc_pkg: shared FSM state type, LFSR tap mask and LFSR step function for the stochastic divider controller
package sc_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;
  localparam logic [5:0] LFSR_TAPS = 6'b110000;
  function automatic logic [5:0] lfsr6_step(input logic [5:0] q);
    return {q[4:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/sc_div_ctrl_if.sv
// sc_div_ctrl_if: request/response handshake bundle; master issues requests, slave (controller) answers
interface sc_div_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic [5:0] req_a;
  logic [5:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [7:0] rsp_q;
  logic rsp_err;
  modport master (output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_q, rsp_err);
  modport slave (input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_q, rsp_err);
endinterface

// File: rtl/lfsr6.sv
// lfsr6: 6-bit Fibonacci LFSR (x^6+x^5+1); async active-low reset and load to seed, steps when en
module lfsr6
  import sc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [5:0] seed,
  output logic [5:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= seed;
    else if (load) q <= seed;
    else if (en) q <= lfsr6_step(q);
endmodule

// File: rtl/sc_div_ctrl.sv
// sc_div_ctrl: drives an external stochastic divider with LFSR bitstreams and counts quotient ones; req/rsp via bus, div_* to divider
module sc_div_ctrl
  import sc_pkg::*;
#(
  parameter int WARMUP = 16,
  parameter int LEN = 64,
  parameter logic [5:0] SEED_A = 6'h2A,
  parameter logic [5:0] SEED_B = 6'h15,
  parameter logic [5:0] SEED_R = 6'h33
) (
  input  logic            clk,
  input  logic            rst_n,
  sc_div_ctrl_if.slave    bus,
  output logic            div_rst_n,
  output logic            div_dividend,
  output logic            div_divisor,
  output logic [5:0]      div_rand,
  input  logic            div_quotient
);
  state_t state, nxt;
  logic [5:0] a_lat, b_lat, q_a, q_b, q_r;
  logic [7:0] cyc, cnt;
  logic err, accept, stream;
  assign accept = state == IDLE && bus.req_valid;
  assign stream = nxt == WARM || nxt == RUN;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == DONE;
  assign bus.rsp_q = cnt;
  assign bus.rsp_err = err;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = bus.req_valid ? CLEAR : IDLE;
      CLEAR:   nxt = b_lat == '0 ? DONE : WARM;
      WARM:    nxt = cyc == 8'(WARMUP - 1) ? RUN : WARM;
      RUN:     nxt = cyc == 8'(LEN - 1) ? DONE : RUN;
      DONE:    nxt = bus.rsp_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  lfsr6 u_lfsr_a (.clk(clk), .rst_n(rst_n), .load(accept), .en(stream), .seed(SEED_A), .q(q_a));
  lfsr6 u_lfsr_b (.clk(clk), .rst_n(rst_n), .load(accept), .en(stream), .seed(SEED_B), .q(q_b));
  lfsr6 u_lfsr_r (.clk(clk), .rst_n(rst_n), .load(accept), .en(stream), .seed(SEED_R), .q(q_r));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_lat <= '0;
      b_lat <= '0;
      cyc <= '0;
      cnt <= '0;
      err <= 1'b0;
      div_rst_n <= 1'b0;
      div_dividend <= 1'b0;
      div_divisor <= 1'b0;
      div_rand <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_lat <= bus.req_a;
        b_lat <= bus.req_b;
      end
      cyc <= state != nxt ? '0 : cyc + 1'b1;
      if (state == CLEAR) begin
        cnt <= b_lat == '0 ? 8'(LEN) : '0;
        err <= b_lat == '0;
      end else if (state == RUN) cnt <= cnt + {7'd0, div_quotient};
      div_rst_n <= !(accept && bus.req_b != '0);
      div_dividend <= stream && a_lat > q_a;
      div_divisor <= stream && b_lat > q_b;
      div_rand <= stream ? q_r : '0;
    end
endmodule

// File: tb/tb_sc_div_ctrl.sv
// tb_sc_div_ctrl: directed self-checking bench with a count-ratio stochastic divider model
module tb_sc_div_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic div_rst_n, div_dividend, div_divisor, div_quotient;
  logic [5:0] div_rand;
  int ca, cb;
  int checks = 0;
  int passed = 0;
  logic [7:0] q_ref;
  sc_div_ctrl_if bus();
  sc_div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .div_rst_n(div_rst_n), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_rand(div_rand), .div_quotient(div_quotient)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!div_rst_n) begin
      ca <= 0;
      cb <= 0;
    end else begin
      ca <= ca + int'(div_dividend);
      cb <= cb + int'(div_divisor);
    end
  assign div_quotient = int'(div_rand) * cb < 64 * ca;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [5:0] a, input logic [5:0] b);
    bus.req_a = a;
    bus.req_b = b;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.req_a = 6'($urandom);
    bus.req_b = 6'($urandom);
  endtask
  task automatic wait_done(input int start, output int lat, output bit clr);
    lat = start;
    clr = !div_rst_n;
    while (!bus.rsp_valid && lat < 1000) begin
      step();
      lat++;
      clr |= !div_rst_n;
    end
  endtask
  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    step();
    step();
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); else passed++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else passed++;
    checks++; if (bus.rsp_q !== 8'd0) $display("FAIL reset_rsp_q: got %0d expected 0", bus.rsp_q); else passed++;
    checks++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); else passed++;
    checks++; if (div_rst_n !== 1'b0) $display("FAIL reset_div_rst_n: got %b expected 0", div_rst_n); else passed++;
    checks++; if ({div_dividend, div_divisor, div_rand} !== 8'd0) $display("FAIL reset_streams: got %h expected 00", {div_dividend, div_divisor, div_rand}); else passed++;
    rst_n = 1'b1;
    #1;
    checks++; if (div_rst_n !== 1'b0) $display("FAIL div_rst_n_before_edge: got %b expected 0", div_rst_n); else passed++;
    step();
    checks++; if (div_rst_n !== 1'b1) $display("FAIL div_rst_n_rise: got %b expected 1", div_rst_n); else passed++;
  endtask
  task automatic test_streams();
    int lat;
    bit clr;
    accept(6'd16, 6'd32);
    checks++; if ({div_rst_n, div_rand} !== 7'd0) $display("FAIL clear_cycle: got %h expected 00", {div_rst_n, div_rand}); else passed++;
    step();
    checks++; if ({div_rst_n, div_dividend, div_divisor, div_rand} !== {3'b101, 6'h33}) $display("FAIL warm1_streams: got %h expected %h", {div_rst_n, div_dividend, div_divisor, div_rand}, {3'b101, 6'h33}); else passed++;
    step();
    checks++; if ({div_dividend, div_divisor, div_rand} !== {2'b00, 6'h26}) $display("FAIL warm2_streams: got %h expected %h", {div_dividend, div_divisor, div_rand}, {2'b00, 6'h26}); else passed++;
    wait_done(3, lat, clr);
    checks++; if (lat !== 82) $display("FAIL latency_16_32: got %0d expected 82", lat); else passed++;
    checks++; if (bus.rsp_q < 8'd24 || bus.rsp_q > 8'd40) $display("FAIL q_16_32: got %0d expected 24..40", bus.rsp_q); else passed++;
    checks++; if (bus.rsp_err !== 1'b0) $display("FAIL err_16_32: got %b expected 0", bus.rsp_err); else passed++;
    q_ref = bus.rsp_q;
    finish_rsp();
  endtask
  task automatic test_div_zero();
    int lat;
    bit clr;
    accept(6'd40, 6'd0);
    wait_done(1, lat, clr);
    checks++; if (lat !== 2) $display("FAIL latency_div0: got %0d expected 2", lat); else passed++;
    checks++; if (bus.rsp_q !== 8'd64) $display("FAIL q_div0: got %0d expected 64", bus.rsp_q); else passed++;
    checks++; if (bus.rsp_err !== 1'b1) $display("FAIL err_div0: got %b expected 1", bus.rsp_err); else passed++;
    checks++; if (clr !== 1'b0) $display("FAIL div_rst_n_pulse_div0: got %b expected 0", clr); else passed++;
    finish_rsp();
  endtask
  task automatic test_full();
    int lat;
    bit clr;
    accept(6'd63, 6'd63);
    wait_done(1, lat, clr);
    checks++; if (bus.rsp_q < 8'd56 || lat !== 82) $display("FAIL q_63_63: got q=%0d lat=%0d expected q>=56 lat=82", bus.rsp_q, lat); else passed++;
    checks++; if (bus.rsp_err !== 1'b0) $display("FAIL err_63_63: got %b expected 0", bus.rsp_err); else passed++;
    finish_rsp();
  endtask
  task automatic test_hold();
    int lat;
    bit clr;
    logic [7:0] q0;
    accept(6'd16, 6'd32);
    wait_done(1, lat, clr);
    q0 = bus.rsp_q;
    checks++; if (q0 !== q_ref) $display("FAIL hold_q_repeat: got %0d expected %0d", q0, q_ref); else passed++;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_q} !== {2'b10, q0}) $display("FAIL hold_cycle%0d: got %h expected %h", i, {bus.rsp_valid, bus.req_ready, bus.rsp_q}, {2'b10, q0}); else passed++;
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) $display("FAIL hold_release: got %b expected 10", {bus.req_ready, bus.rsp_valid}); else passed++;
  endtask
  task automatic test_reset_mid();
    int lat;
    bit clr;
    accept(6'd16, 6'd32);
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_q, bus.rsp_err, div_rst_n, div_dividend, div_divisor, div_rand} !== {2'b10, 8'd0, 4'b0000, 6'd0})
      $display("FAIL mid_reset_outputs: got %h expected %h", {bus.req_ready, bus.rsp_valid, bus.rsp_q, bus.rsp_err, div_rst_n, div_dividend, div_divisor, div_rand}, {2'b10, 8'd0, 4'b0000, 6'd0}); else passed++;
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) $display("FAIL mid_reset_no_rsp: got %b expected 01", {bus.rsp_valid, bus.req_ready}); else passed++;
    accept(6'd16, 6'd32);
    wait_done(1, lat, clr);
    checks++; if (lat !== 82) $display("FAIL mid_reset_latency: got %0d expected 82", lat); else passed++;
    checks++; if (bus.rsp_q !== q_ref) $display("FAIL mid_reset_q: got %0d expected %0d", bus.rsp_q, q_ref); else passed++;
    finish_rsp();
  endtask
  task automatic test_back_to_back();
    int lat;
    bit clr;
    logic [7:0] q1;
    accept(6'd40, 6'd50);
    wait_done(1, lat, clr);
    q1 = bus.rsp_q;
    finish_rsp();
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", bus.req_ready); else passed++;
    accept(6'd40, 6'd50);
    wait_done(1, lat, clr);
    checks++; if (lat !== 82) $display("FAIL b2b_latency: got %0d expected 82", lat); else passed++;
    checks++; if (bus.rsp_q !== q1) $display("FAIL b2b_q: got %0d expected %0d", bus.rsp_q, q1); else passed++;
    finish_rsp();
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_streams();
    test_div_zero();
    test_full();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sc_div_ctrl.md
SC_DIV_CTRL -- requirements
Module: sc_div_ctrl

Interface
REQ-001 Parameter WARMUP, default 16, sets the number of settling cycles (1..255) before accumulation starts.
REQ-002 Parameter LEN, default 64, sets the number of accumulation cycles (1..255).
REQ-003 Parameters SEED_A / SEED_B / SEED_R, defaults 6'h2A / 6'h15 / 6'h33, are nonzero LFSR seeds.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  operation request.
REQ-007 req_ready  out  1  block is idle and accepts a request.
REQ-008 req_a  in  6  dividend magnitude.
REQ-009 req_b  in  6  divisor magnitude.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  result consumed.
REQ-012 rsp_q  out  8  count of quotient ones over LEN cycles.
REQ-013 rsp_err  out  1  divide-by-zero flag.
REQ-014 div_rst_n  out  1  registered active-low clear to the stochastic divider.
REQ-015 div_dividend  out  1  dividend bitstream.
REQ-016 div_divisor  out  1  divisor bitstream.
REQ-017 div_rand  out  6  random compare value to the divider.
REQ-018 div_quotient  in  1  divider output bitstream.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, WARM, RUN and DONE.
REQ-020 IDLE: req_ready=1; on req_valid, latch req_a/req_b and go to CLEAR; in every other state req_ready=0.
REQ-021 Accept with latched b==0: go directly to DONE next cycle with rsp_q=LEN and rsp_err=1; no divider activity.
REQ-022 CLEAR (1 cycle): div_rst_n=0 that cycle; all three LFSRs reload their seeds; go to WARM.
REQ-023 WARM: run WARMUP cycles without accumulating, then go to RUN.
REQ-024 RUN: run LEN cycles, adding div_quotient sampled each cycle to an 8-bit counter, then go to DONE.
REQ-025 The counter SHALL be zeroed in CLEAR and SHALL never exceed LEN, so it never wraps.
REQ-026 DONE: rsp_valid=1 and rsp_q/rsp_err held stable until rsp_ready=1, then go to IDLE next cycle.
REQ-027 rsp_valid SHALL be 0 in every state other than DONE.
REQ-028 Lfsr6 stepping: each LFSR is a 6-bit maximal-length Fibonacci LFSR (x^6+x^5+1) with period 63 and never 0; it steps every WARM/RUN cycle and holds otherwise.
REQ-029 In WARM/RUN: div_dividend = (a_lat > lfsrA), div_divisor = (b_lat > lfsrB), div_rand = lfsrR. All are registered outputs.
REQ-030 In IDLE/CLEAR/DONE: div_dividend=0, div_divisor=0, div_rand=0.
REQ-031 Latency: accept at cycle T (b≠0) SHALL give rsp_valid=1 at T+2+WARMUP+LEN.
REQ-032 The block SHALL accept a new request no earlier than the cycle after the DONE handshake.
REQ-033 Inputs req_a/req_b SHALL be ignored outside the accept cycle.

Reset
REQ-034 On rst_n low, all state SHALL clear: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_q=0, rsp_err=0, div_rst_n=0, stream outputs=0, LFSRs=seeds.
REQ-035 div_rst_n SHALL rise on the first clk edge after rst_n deasserts.
REQ-036 Reset mid-operation SHALL abandon the operation with no response.

Structure
REQ-037 The state enum and the LFSR tap constant SHALL reside in shared package sc_pkg.
REQ-038 The LFSR SHALL be a sub-module lfsr6 (ports: clk, rst_n, load, en, seed, q) instantiated three times.
REQ-039 The divider itself SHALL be external to this block; the controller only drives and observes it.

Verification
REQ-040 Scenario a=16, b=32, defaults: rsp_valid at T+82, rsp_q in 24..40, rsp_err=0.
REQ-041 Scenario b=0, a=40: rsp_valid at T+2, rsp_q=64, rsp_err=1, div_rst_n never pulses.
REQ-042 Scenario a=63, b=63: rsp_q ≥ 56.
REQ-043 Scenario rsp_ready held low 10 cycles in DONE: rsp_valid/rsp_q stable and req_ready=0 throughout; IDLE follows the cycle after rsp_ready=1.
REQ-044 Scenario rst_n asserted mid-RUN: all outputs at reset values immediately; a later request completes normally with the same rsp_q as an undisturbed identical run.
REQ-045 Scenario two identical back-to-back requests: identical rsp_q, because the LFSRs reseed in CLEAR.
